// File: rtl/invader_fleet.sv
// Invader fleet game logic: stepping movement, bullet hit detection, explosion timing,
// wave reload and game-over handling for a row of ten invaders.
module invader_fleet #(
   parameter int unsigned STEP_CYCLES    = 600000,
   parameter int unsigned STEP_PX        = 4,
   parameter int unsigned INV_W          = 16,
   parameter int unsigned INV_H          = 12,
   parameter int unsigned INV_PITCH      = 32,
   parameter int unsigned LINE_H         = 16,
   parameter int unsigned SCREEN_W       = 640,
   parameter int unsigned LINE_LIMIT     = 26,
   parameter int unsigned EXPLODE_CYCLES = 1200000
) (
   input  logic        clk_12MHz,
   input  logic        reset,
   input  logic        enable,
   input  logic        start,
   input  logic [9:0]  bullet_x,
   input  logic [9:0]  bullet_y,
   input  logic        bullet_flying,
   output logic [19:0] invaders_array,
   output logic [4:0]  invaders_line,
   output logic [9:0]  fleet_x,
   output logic        hit,
   output logic        wave_clear,
   output logic        game_over
);

   localparam int unsigned NUM_INV = 10;
   localparam int unsigned STEP_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int unsigned EXP_W   = $clog2(EXPLODE_CYCLES + 1);
   localparam logic [19:0] ALL_ALIVE  = 20'hAAAAA;
   localparam logic [10:0] RIGHT_SPAN = 11'((NUM_INV - 1) * INV_PITCH + INV_W + STEP_PX);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [EXP_W-1:0]  EXP_LOAD  = EXP_W'(EXPLODE_CYCLES);

   typedef enum logic [1:0] {StPlay, StWaveClear, StGameOver} state_e;

   state_e            state_q, state_d;
   logic [19:0]       inv_q, inv_d;
   logic [4:0]        line_q, line_d;
   logic [9:0]        fx_q, fx_d;
   logic              dir_left_q, dir_left_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [EXP_W-1:0]  exp_cnt_q [NUM_INV];
   logic [EXP_W-1:0]  exp_cnt_d [NUM_INV];
   logic              armed_q, armed_d;
   logic              hit_q, hit_d;
   logic              wave_clear_q, wave_clear_d;
   logic              game_over_q, game_over_d;

   logic [NUM_INV-1:0] match, hit_sel;
   logic               hit_found, alive_any, step_ev, reload;
   logic [10:0]        top_y, left_x, bx, by;

   // Geometric hit test uses the registered (pre-step) position
   always_comb begin
      bx        = {1'b0, bullet_x};
      by        = {1'b0, bullet_y};
      top_y     = 11'(line_q) * 11'(LINE_H);
      left_x    = '0;
      match     = '0;
      hit_sel   = '0;
      hit_found = 1'b0;
      alive_any = 1'b0;
      for (int i = 0; i < NUM_INV; i++) begin
         left_x   = 11'(fx_q) + 11'(i * INV_PITCH);
         match[i] = (inv_q[2*i +: 2] == 2'b10) && (bx >= left_x) && (bx < left_x + 11'(INV_W))
                    && (by >= top_y) && (by < top_y + 11'(INV_H));
         if (inv_q[2*i +: 2] == 2'b10) alive_any = 1'b1;
      end
      for (int i = 0; i < NUM_INV; i++) begin
         if (match[i] && !hit_found && state_q == StPlay && bullet_flying && armed_q) begin
            hit_sel[i] = 1'b1;
            hit_found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      inv_d        = inv_q;
      line_d       = line_q;
      fx_d         = fx_q;
      dir_left_d   = dir_left_q;
      step_cnt_d   = step_cnt_q;
      exp_cnt_d    = exp_cnt_q;
      armed_d      = armed_q;
      hit_d        = 1'b0;
      wave_clear_d = 1'b0;
      step_ev      = 1'b0;
      reload       = 1'b0;

      if (!bullet_flying) armed_d = 1'b1;

      unique case (state_q)
         StPlay: begin
            if (enable) begin
               if (step_cnt_q == STEP_LAST) begin
                  step_cnt_d = '0;
                  step_ev    = 1'b1;
               end else begin
                  step_cnt_d = step_cnt_q + STEP_W'(1);
               end
               // Explosion ends on the same edge its timer reaches zero
               for (int i = 0; i < NUM_INV; i++) begin
                  if (inv_q[2*i +: 2] == 2'b01) begin
                     exp_cnt_d[i] = (exp_cnt_q[i] > EXP_W'(0)) ? exp_cnt_q[i] - EXP_W'(1) : '0;
                     if (exp_cnt_q[i] <= EXP_W'(1)) inv_d[2*i +: 2] = 2'b00;
                  end
               end
            end
            if (step_ev) begin
               if (!dir_left_q) begin
                  if ({1'b0, fx_q} + RIGHT_SPAN <= 11'(SCREEN_W)) begin
                     fx_d = fx_q + 10'(STEP_PX);
                  end else begin
                     if (line_q != 5'(LINE_LIMIT)) line_d = line_q + 5'd1;
                     dir_left_d = 1'b1;
                  end
               end else begin
                  if (fx_q >= 10'(STEP_PX)) begin
                     fx_d = fx_q - 10'(STEP_PX);
                  end else begin
                     if (line_q != 5'(LINE_LIMIT)) line_d = line_q + 5'd1;
                     dir_left_d = 1'b0;
                  end
               end
            end
            for (int i = 0; i < NUM_INV; i++) begin
               if (hit_sel[i]) begin
                  inv_d[2*i +: 2] = 2'b01;
                  exp_cnt_d[i]    = EXP_LOAD;
               end
            end
            if (hit_found) begin
               hit_d   = 1'b1;
               armed_d = 1'b0;
            end
            if (inv_d == '0) begin
               wave_clear_d = 1'b1;
               state_d      = StWaveClear;
            end else if (line_q == 5'(LINE_LIMIT) && alive_any) begin
               state_d = StGameOver;
            end
         end
         StWaveClear: begin
            reload  = 1'b1;
            state_d = StPlay;
         end
         StGameOver: begin
            if (start) begin
               reload  = 1'b1;
               state_d = StPlay;
            end
         end
         default: state_d = StPlay;
      endcase

      if (reload) begin
         inv_d      = ALL_ALIVE;
         line_d     = '0;
         fx_d       = '0;
         dir_left_d = 1'b0;
         step_cnt_d = '0;
         for (int i = 0; i < NUM_INV; i++) exp_cnt_d[i] = '0;
      end

      game_over_d = (state_d == StGameOver);
   end

   always_ff @(posedge clk_12MHz or posedge reset) begin
      if (reset) begin
         state_q      <= StPlay;
         inv_q        <= ALL_ALIVE;
         line_q       <= '0;
         fx_q         <= '0;
         dir_left_q   <= 1'b0;
         step_cnt_q   <= '0;
         exp_cnt_q    <= '{default: '0};
         armed_q      <= 1'b1;
         hit_q        <= 1'b0;
         wave_clear_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         inv_q        <= inv_d;
         line_q       <= line_d;
         fx_q         <= fx_d;
         dir_left_q   <= dir_left_d;
         step_cnt_q   <= step_cnt_d;
         exp_cnt_q    <= exp_cnt_d;
         armed_q      <= armed_d;
         hit_q        <= hit_d;
         wave_clear_q <= wave_clear_d;
         game_over_q  <= game_over_d;
      end
   end

   assign invaders_array = inv_q;
   assign invaders_line  = line_q;
   assign fleet_x        = fx_q;
   assign hit            = hit_q;
   assign wave_clear     = wave_clear_q;
   assign game_over      = game_over_q;

endmodule

// File: tb/tb_invader_fleet.sv
// Bench for invader_fleet: a cycle model compared every cycle, plus directed scenarios
// with hand-computed expectations (STEP_CYCLES=4, EXPLODE_CYCLES=6).
module tb_invader_fleet;

   localparam int STEP  = 4;
   localparam int EXPL  = 6;
   localparam int PLAY  = 0;
   localparam int WCLR  = 1;
   localparam int GOVER = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic        bullet_flying = 1'b0;
   logic [9:0]  bullet_x = '0;
   logic [9:0]  bullet_y = '0;
   logic [19:0] invaders_array;
   logic [4:0]  invaders_line;
   logic [9:0]  fleet_x;
   logic        hit, wave_clear, game_over;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   invader_fleet #(
      .STEP_CYCLES(STEP),
      .EXPLODE_CYCLES(EXPL)
   ) dut (
      .clk_12MHz(clk),
      .reset(reset),
      .enable(enable),
      .start(start),
      .bullet_x(bullet_x),
      .bullet_y(bullet_y),
      .bullet_flying(bullet_flying),
      .invaders_array(invaders_array),
      .invaders_line(invaders_line),
      .fleet_x(fleet_x),
      .hit(hit),
      .wave_clear(wave_clear),
      .game_over(game_over)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: invader state 2=alive, 1=exploding, 0=dead
   int m_inv[10];
   int m_tmr[10];
   int m_x, m_line, m_left, m_cnt, m_state, m_armed, m_hit, m_wc;

   task automatic m_reload();
      for (int i = 0; i < 10; i++) begin
         m_inv[i] = 2;
         m_tmr[i] = 0;
      end
      m_x = 0; m_line = 0; m_left = 0; m_cnt = 0;
   endtask

   function automatic logic [19:0] m_pack();
      logic [19:0] v;
      v = '0;
      for (int i = 0; i < 10; i++)
         v[2*i +: 2] = (m_inv[i] == 2) ? 2'b10 : (m_inv[i] == 1) ? 2'b01 : 2'b00;
      return v;
   endfunction

   task automatic m_step();
      int hi, line0, bx, by, x0;
      bit any_alive, all_dead, step_now;
      hi = -1; m_hit = 0; m_wc = 0; line0 = m_line;
      bx = int'(bullet_x); by = int'(bullet_y);
      any_alive = 0;
      for (int i = 0; i < 10; i++) if (m_inv[i] == 2) any_alive = 1;
      if (m_state == PLAY && bullet_flying && m_armed != 0)
         for (int i = 0; i < 10; i++) begin
            x0 = m_x + 32 * i;
            if (hi < 0 && m_inv[i] == 2 && bx >= x0 && bx < x0 + 16 &&
                by >= m_line * 16 && by < m_line * 16 + 12) hi = i;
         end
      if (!bullet_flying) m_armed = 1;
      case (m_state)
         PLAY: begin
            step_now = 0;
            if (enable) begin
               step_now = (m_cnt == STEP - 1);
               m_cnt = (m_cnt + 1) % STEP;
               for (int i = 0; i < 10; i++)
                  if (m_inv[i] == 1) begin
                     m_tmr[i]--;
                     if (m_tmr[i] == 0) m_inv[i] = 0;
                  end
            end
            if (step_now) begin
               if (m_left == 0) begin
                  if (m_x + 9 * 32 + 16 + 4 <= 640) m_x += 4;
                  else begin
                     if (m_line < 26) m_line++;
                     m_left = 1;
                  end
               end else begin
                  if (m_x >= 4) m_x -= 4;
                  else begin
                     if (m_line < 26) m_line++;
                     m_left = 0;
                  end
               end
            end
            if (hi >= 0) begin
               m_inv[hi] = 1; m_tmr[hi] = EXPL; m_hit = 1; m_armed = 0;
            end
            all_dead = 1;
            for (int i = 0; i < 10; i++) if (m_inv[i] != 0) all_dead = 0;
            if (all_dead) begin
               m_wc = 1; m_state = WCLR;
            end else if (line0 == 26 && any_alive) m_state = GOVER;
         end
         WCLR: begin
            m_reload(); m_state = PLAY;
         end
         default: if (start) begin
            m_reload(); m_state = PLAY;
         end
      endcase
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_reload(); m_state = PLAY; m_armed = 1; m_hit = 0; m_wc = 0;
      end else begin
         m_step();
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         check("cmp_array", invaders_array, m_pack());
         check("cmp_line", invaders_line, m_line);
         check("cmp_fleet_x", fleet_x, m_x);
         check("cmp_hit", hit, m_hit);
         check("cmp_wave_clear", wave_clear, m_wc);
         check("cmp_game_over", game_over, (m_state == GOVER) ? 1 : 0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int hits;
      #1 reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      enable = 1'b1;
      check("reset_array", invaders_array, 20'hAAAAA);
      check("reset_line", invaders_line, 0);
      check("reset_x", fleet_x, 0);
      check("reset_flags", {hit, wave_clear, game_over}, 0);

      // Three steps, then sweep right to the edge and drop
      cyc(12);
      check("three_steps_x", fleet_x, 12);
      check("three_steps_line", invaders_line, 0);
      check("three_steps_array", invaders_array, 20'hAAAAA);
      check("three_steps_hit", hit, 0);
      cyc(324);
      check("edge_x", fleet_x, 336);
      check("edge_line", invaders_line, 0);
      cyc(4);
      check("drop_x", fleet_x, 336);
      check("drop_line", invaders_line, 1);
      cyc(4);
      check("left_x", fleet_x, 332);

      // Single hit on invader 2, explosion, then dead invader is not hit again
      do_reset();
      bullet_x = 10'd70; bullet_y = 10'd5; bullet_flying = 1'b1;
      hits = 0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         if (k == 0) begin
            check("hit2_pulse", hit, 1);
            check("hit2_exploding", invaders_array[5:4], 2'b01);
         end
         hits += int'(hit);
      end
      check("one_hit_per_bullet", hits, 1);
      bullet_flying = 1'b0;
      cyc(1);
      check("hit2_still_exploding", invaders_array[5:4], 2'b01);
      cyc(1);
      check("hit2_dead", invaders_array[5:4], 2'b00);
      check("hit2_fleet_x", fleet_x, 4);
      enable = 1'b0;
      bullet_x = 10'd74; bullet_flying = 1'b1;
      hits = 0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         hits += int'(hit);
      end
      check("dead_not_hit", hits, 0);
      bullet_flying = 1'b0;
      cyc(1);

      // Boundaries of the invader-0 box
      do_reset();
      enable = 1'b0;
      bullet_x = 10'd16; bullet_y = 10'd5; bullet_flying = 1'b1;
      cyc(1);
      check("gap_x16_no_hit", hit, 0);
      check("gap_x16_array", invaders_array, 20'hAAAAA);
      bullet_flying = 1'b0; cyc(1);
      bullet_x = 10'd15; bullet_y = 10'd12; bullet_flying = 1'b1;
      cyc(1);
      check("y12_no_hit", hit, 0);
      bullet_flying = 1'b0; cyc(1);
      bullet_x = 10'd15; bullet_y = 10'd11; bullet_flying = 1'b1;
      cyc(1);
      check("corner_15_11_hit", hit, 1);
      check("corner_15_11_inv0", invaders_array[1:0], 2'b01);
      bullet_flying = 1'b0; cyc(1);

      // Hit on the same edge as a step uses the pre-step position
      do_reset();
      enable = 1'b1;
      cyc(3);
      bullet_x = 10'd2; bullet_y = 10'd5; bullet_flying = 1'b1;
      cyc(1);
      check("step_hit_pulse", hit, 1);
      check("step_hit_x", fleet_x, 4);
      check("step_hit_inv0", invaders_array[1:0], 2'b01);
      bullet_flying = 1'b0; cyc(1);

      // Destroy all ten, explosions run concurrently, then wave clear and reload
      do_reset();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         bullet_x = 10'(32 * i + 5); bullet_y = 10'd5; bullet_flying = 1'b1;
         cyc(1);
         check("kill_hit", hit, 1);
         bullet_flying = 1'b0;
         cyc(1);
      end
      check("all_exploding", invaders_array, 20'h55555);
      enable = 1'b1;
      cyc(5);
      check("pre_clear_array", invaders_array, 20'h55555);
      check("pre_clear_wc", wave_clear, 0);
      cyc(1);
      check("clear_wc", wave_clear, 1);
      check("clear_array", invaders_array, 20'h00000);
      cyc(1);
      check("post_clear_wc", wave_clear, 0);
      check("reload_array", invaders_array, 20'hAAAAA);
      check("reload_x", fleet_x, 0);
      check("reload_line", invaders_line, 0);

      // March down to the ship: game over, halt, then restart
      do_reset();
      enable = 1'b1;
      cyc(8500);
      check("line25_line", invaders_line, 25);
      check("line25_x", fleet_x, 336);
      cyc(340);
      check("line26_line", invaders_line, 26);
      check("line26_x", fleet_x, 0);
      check("line26_not_over_yet", game_over, 0);
      cyc(1);
      check("game_over_set", game_over, 1);
      bullet_x = 10'd5; bullet_y = 10'd420; bullet_flying = 1'b1;
      hits = 0;
      for (int k = 0; k < 20; k++) begin
         cyc(1);
         hits += int'(hit);
      end
      check("over_no_hits", hits, 0);
      check("over_hold_line", invaders_line, 26);
      check("over_hold_x", fleet_x, 0);
      check("over_hold_flag", game_over, 1);
      bullet_flying = 1'b0; start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("restart_flag", game_over, 0);
      check("restart_array", invaders_array, 20'hAAAAA);
      check("restart_line", invaders_line, 0);
      check("restart_x", fleet_x, 0);
      cyc(4);
      check("restart_moves", fleet_x, 4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
